pipelined_alu: RTL and testbench
================================

PIPELINED_ALU -- requirements
Module: pipelined_alu

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand/result width.
REQ-002 SHALL have parameter LATENCY, default 4, pipeline stages from accept to output; legal range 1..16.
REQ-003 SHALL have parameter TAG_WIDTH, default 6, opaque in-flight tag (instruction ID + rd).
REQ-004 SHALL have parameter PAYLOAD_WIDTH, default 128, opaque side-band carried alongside (decode packet, bypass data).
REQ-005 SHALL use one clock and a synchronous, active-high reset, with ports named clock and reset as listed below.
REQ-006 clock  input  1  rising-edge clock.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 flush  input  1  kill all in-flight operations.
REQ-009 in_valid  input  1  request present.
REQ-010 in_ready  output  1  request accepted when in_valid&in_ready.
REQ-011 alu_control  input  6  opcode; same encodings as the existing ALU.
REQ-012 operand_a, operand_b  input  DATA_WIDTH  operands.
REQ-013 in_tag  input  TAG_WIDTH;  in_payload  input  PAYLOAD_WIDTH.
REQ-014 out_valid  output  1;  out_ready  input  1  consumer accepts.
REQ-015 out_result  output  DATA_WIDTH;  out_zero, out_branch  output  1.
REQ-016 out_tag  output  TAG_WIDTH;  out_payload  output  PAYLOAD_WIDTH.
REQ-017 occupancy  output  5  count of valid stages.

Function
REQ-018 Result, zero and branch SHALL be computed combinationally at accept and registered into stage 0; later stages only carry them.
REQ-019 SLT/SLTI, BLT and BGE SHALL compare signed; SLTU, BLTU and BGEU SHALL compare unsigned.
REQ-020 SRA SHALL shift in the sign bit.
REQ-021 All shifts SHALL use operand_b[4:0].
REQ-022 Undefined opcodes SHALL yield result 0.
REQ-023 zero SHALL equal (result == 0).
REQ-024 branch SHALL equal (alu_control[4:3]==2'b10 & result==1).
REQ-025 Each stage SHALL hold one valid bit plus the full data set.
REQ-026 Stage i SHALL advance when stage i+1 is empty or advancing.
REQ-027 The last stage SHALL advance when out_ready is high.
REQ-028 Empty stages SHALL be filled (bubble collapse), so the pipe never stalls behind a bubble.
REQ-029 in_ready SHALL equal (~stage0_valid | stage0_advances) & ~flush; this path is combinational from out_ready.
REQ-030 With no backpressure, a request accepted at edge N SHALL present out_valid with its data after edge N+LATENCY-1, i.e. on the LATENCY-th edge counting the accept edge.
REQ-031 Throughput SHALL be one request per cycle sustained.
REQ-032 Output data SHALL be held stable while out_valid & ~out_ready.
REQ-033 Ordering SHALL be strict FIFO.
REQ-034 Full pipe: occupancy==LATENCY; a simultaneous out handshake and in handshake SHALL keep it full with no loss.
REQ-035 flush SHALL clear every valid bit at the next edge and block same-cycle acceptance; flush wins over in_valid and out_ready.
REQ-036 occupancy SHALL equal the popcount of stage valid bits, updated every edge.
REQ-037 Data registers of invalid stages are don't-care but SHALL NOT produce X on the outputs after reset.

Reset
REQ-038 On reset all valid bits, out_valid and occupancy SHALL become 0; out_result, out_tag, out_payload, out_zero and out_branch SHALL become 0.
REQ-039 Reset mid-operation SHALL discard in-flight work with no output.
REQ-040 in_ready SHALL be 0 while reset is high and 1 on the first cycle after reset.

Structure
REQ-041 Opcode localparams (ADD=6'b000000, SUB=6'b001000, ... BGEU=6'b010111) SHALL reside in shared package alu_pkg, alongside the opcode field width.
REQ-042 The combinational compute SHALL be sub-module alu_core (operands+opcode -> result, zero, branch); stage registers live in generate loops in pipelined_alu.

Verification
REQ-043 Reset, then ADD 5+7 at edge 0, out_ready=1, LATENCY=4 -> out_valid after edge 3, out_result=12, out_zero=0, out_tag echoed.
REQ-044 SLT with a=32'hFFFF_FFFF, b=1 -> result 1; SLTU same operands -> 0; BLT -> branch=1.
REQ-045 Back-to-back 6 requests, out_ready=0 -> in_ready drops after 4 accepts, occupancy=4; out_ready=1 -> 6 results in order, one per cycle, no loss.
REQ-046 Requests spaced 2 cycles apart with out_ready toggling 1/0 -> bubbles collapse; held output stays stable while out_ready=0.
REQ-047 Pipe holding 3 ops, flush pulsed with in_valid=1 -> next edge occupancy=0, out_valid=0, the flush-cycle request not accepted.
REQ-048 Reset asserted with 2 ops in flight -> no out_valid afterwards, all outputs 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode encodings and helpers for the ALU family.
// Branch compares occupy the 2'b10 group of alu_control[4:3].
package alu_pkg;

  localparam int ALU_CTRL_WIDTH = 6;

  typedef logic [ALU_CTRL_WIDTH-1:0] alu_ctrl_t;

  localparam alu_ctrl_t ADD  = 6'b000000;
  localparam alu_ctrl_t SLL  = 6'b000001;
  localparam alu_ctrl_t SLT  = 6'b000010;
  // SLTI reuses the SLT encoding; the immediate is selected before operand_b.
  localparam alu_ctrl_t SLTI = 6'b000010;
  localparam alu_ctrl_t SLTU = 6'b000011;
  localparam alu_ctrl_t XOR  = 6'b000100;
  localparam alu_ctrl_t SRL  = 6'b000101;
  localparam alu_ctrl_t OR   = 6'b000110;
  localparam alu_ctrl_t AND  = 6'b000111;
  localparam alu_ctrl_t SUB  = 6'b001000;
  localparam alu_ctrl_t SRA  = 6'b001101;
  localparam alu_ctrl_t BEQ  = 6'b010000;
  localparam alu_ctrl_t BNE  = 6'b010001;
  localparam alu_ctrl_t BLT  = 6'b010100;
  localparam alu_ctrl_t BGE  = 6'b010101;
  localparam alu_ctrl_t BLTU = 6'b010110;
  localparam alu_ctrl_t BGEU = 6'b010111;

  function automatic logic is_branch_op(input alu_ctrl_t op);
    return op[4:3] == 2'b10;
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: operands + opcode -> result, zero flag, branch-taken flag.
// Branch opcodes produce a 0/1 result; undefined opcodes produce 0.
module alu_core
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [ALU_CTRL_WIDTH-1:0] alu_control,
  input  logic [DATA_WIDTH-1:0]     operand_a,
  input  logic [DATA_WIDTH-1:0]     operand_b,
  output logic [DATA_WIDTH-1:0]     result,
  output logic                      zero,
  output logic                      branch
);

  logic [4:0] shamt;
  logic       signed_lt;
  logic       unsigned_lt;
  logic       equal;

  assign shamt       = operand_b[4:0];
  assign signed_lt   = $signed(operand_a) < $signed(operand_b);
  assign unsigned_lt = operand_a < operand_b;
  assign equal       = operand_a == operand_b;

  always_comb begin
    // NOTE: default assigned first so no opcode path can infer a latch.
    result = '0;
    case (alu_control)
      ADD:  result = operand_a + operand_b;
      SUB:  result = operand_a - operand_b;
      SLL:  result = operand_a << shamt;
      SRL:  result = operand_a >> shamt;
      SRA:  result = $unsigned($signed(operand_a) >>> shamt);
      SLT:  result = DATA_WIDTH'(signed_lt);
      SLTU: result = DATA_WIDTH'(unsigned_lt);
      XOR:  result = operand_a ^ operand_b;
      OR:   result = operand_a | operand_b;
      AND:  result = operand_a & operand_b;
      BEQ:  result = DATA_WIDTH'(equal);
      BNE:  result = DATA_WIDTH'(!equal);
      BLT:  result = DATA_WIDTH'(signed_lt);
      BGE:  result = DATA_WIDTH'(!signed_lt);
      BLTU: result = DATA_WIDTH'(unsigned_lt);
      BGEU: result = DATA_WIDTH'(!unsigned_lt);
      default: result = '0;
    endcase
  end

  assign zero   = result == '0;
  assign branch = is_branch_op(alu_control) && (result == DATA_WIDTH'(1));

endmodule

// File: rtl/pipelined_alu.sv
// Valid/ready ALU pipeline: compute at accept, then carry the result through
// LATENCY (1..16) elastic stages that collapse bubbles and stay strictly FIFO.
module pipelined_alu
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int LATENCY       = 4,
  parameter int TAG_WIDTH     = 6,
  parameter int PAYLOAD_WIDTH = 128
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [ALU_CTRL_WIDTH-1:0] alu_control,
  input  logic [DATA_WIDTH-1:0]     operand_a,
  input  logic [DATA_WIDTH-1:0]     operand_b,
  input  logic [TAG_WIDTH-1:0]      in_tag,
  input  logic [PAYLOAD_WIDTH-1:0]  in_payload,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH-1:0]     out_result,
  output logic                      out_zero,
  output logic                      out_branch,
  output logic [TAG_WIDTH-1:0]      out_tag,
  output logic [PAYLOAD_WIDTH-1:0]  out_payload,
  output logic [4:0]                occupancy
);

  logic [LATENCY-1:0]       valid_q;
  logic [LATENCY-1:0]       can_take;
  logic [DATA_WIDTH-1:0]    result_q  [LATENCY];
  logic                     zero_q    [LATENCY];
  logic                     branch_q  [LATENCY];
  logic [TAG_WIDTH-1:0]     tag_q     [LATENCY];
  logic [PAYLOAD_WIDTH-1:0] payload_q [LATENCY];

  logic [DATA_WIDTH-1:0]    alu_result;
  logic                     alu_zero;
  logic                     alu_branch;
  logic                     accept;

  alu_core #(.DATA_WIDTH(DATA_WIDTH)) u_alu_core (
    .alu_control (alu_control),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .result      (alu_result),
    .zero        (alu_zero),
    .branch      (alu_branch)
  );

  // A stage can load when it is empty or its content moves on this edge;
  // the chain ripples back from out_ready so in_ready sees it the same cycle.
  always_comb begin
    can_take = '0;
    can_take[LATENCY-1] = ~valid_q[LATENCY-1] | out_ready;
    for (int i = LATENCY - 2; i >= 0; i--) begin
      can_take[i] = ~valid_q[i] | can_take[i+1];
    end
  end

  assign in_ready = can_take[0] & ~flush & ~reset;
  assign accept   = in_valid & in_ready;

  for (genvar i = 0; i < LATENCY; i++) begin : g_stage
    logic                     src_valid;
    logic [DATA_WIDTH-1:0]    src_result;
    logic                     src_zero;
    logic                     src_branch;
    logic [TAG_WIDTH-1:0]     src_tag;
    logic [PAYLOAD_WIDTH-1:0] src_payload;

    if (i == 0) begin : g_head
      assign src_valid   = accept;
      assign src_result  = alu_result;
      assign src_zero    = alu_zero;
      assign src_branch  = alu_branch;
      assign src_tag     = in_tag;
      assign src_payload = in_payload;
    end else begin : g_body
      assign src_valid   = valid_q[i-1];
      assign src_result  = result_q[i-1];
      assign src_zero    = zero_q[i-1];
      assign src_branch  = branch_q[i-1];
      assign src_tag     = tag_q[i-1];
      assign src_payload = payload_q[i-1];
    end

    always_ff @(posedge clock) begin
      if (reset) begin
        valid_q[i]   <= 1'b0;
        // NOTE: data registers are reset as well so the outputs read 0, never X.
        result_q[i]  <= '0;
        zero_q[i]    <= 1'b0;
        branch_q[i]  <= 1'b0;
        tag_q[i]     <= '0;
        payload_q[i] <= '0;
      end else begin
        // NOTE: non-blocking so every stage samples its neighbour's pre-edge value.
        if (flush) begin
          valid_q[i] <= 1'b0;
        end else if (can_take[i]) begin
          valid_q[i] <= src_valid;
        end
        if (can_take[i] && src_valid) begin
          result_q[i]  <= src_result;
          zero_q[i]    <= src_zero;
          branch_q[i]  <= src_branch;
          tag_q[i]     <= src_tag;
          payload_q[i] <= src_payload;
        end
      end
    end
  end

  always_comb begin
    occupancy = '0;
    for (int i = 0; i < LATENCY; i++) begin
      occupancy = occupancy + 5'(valid_q[i]);
    end
  end

  assign out_valid   = valid_q[LATENCY-1];
  assign out_result  = result_q[LATENCY-1];
  assign out_zero    = zero_q[LATENCY-1];
  assign out_branch  = branch_q[LATENCY-1];
  assign out_tag     = tag_q[LATENCY-1];
  assign out_payload = payload_q[LATENCY-1];

endmodule

// File: tb/tb_pipelined_alu.sv
// Self-checking bench for pipelined_alu: opcode table through a scoreboard,
// plus latency, backpressure, bubble, flush and reset sequences.
module tb_pipelined_alu;
  import alu_pkg::*;

  localparam int DW  = 32;
  localparam int LAT = 4;
  localparam int TW  = 6;
  localparam int PW  = 128;

  logic          clock = 1'b0;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [5:0]    alu_control;
  logic [DW-1:0] operand_a;
  logic [DW-1:0] operand_b;
  logic [TW-1:0] in_tag;
  logic [PW-1:0] in_payload;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_result;
  logic          out_zero;
  logic          out_branch;
  logic [TW-1:0] out_tag;
  logic [PW-1:0] out_payload;
  logic [4:0]    occupancy;

  always #5 clock = ~clock;

  pipelined_alu #(
    .DATA_WIDTH(DW), .LATENCY(LAT), .TAG_WIDTH(TW), .PAYLOAD_WIDTH(PW)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_control (alu_control),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .in_tag      (in_tag),
    .in_payload  (in_payload),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_zero    (out_zero),
    .out_branch  (out_branch),
    .out_tag     (out_tag),
    .out_payload (out_payload),
    .occupancy   (occupancy)
  );

  typedef struct packed {
    logic [DW-1:0] result;
    logic          zero;
    logic          branch;
    logic [TW-1:0] tag;
    logic [PW-1:0] payload;
  } exp_t;

  typedef struct {
    logic [5:0]    op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] res;
    logic          br;
  } vec_t;

  exp_t  sb_q[$];
  exp_t  cur_exp;
  exp_t  mon_e;
  vec_t  tbl[20];
  int    n_checks = 0;
  int    n_pass   = 0;

  task automatic check(input string name, input logic [PW-1:0] actual,
                       input logic [PW-1:0] expected);
    n_checks++;
    if (actual !== expected)
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, actual, expected, $time);
    else
      n_pass++;
  endtask

  task automatic drive(input logic [5:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [TW-1:0] tag, input logic [DW-1:0] exp_res,
                       input logic exp_br);
    in_valid    = 1'b1;
    alu_control = op;
    operand_a   = a;
    operand_b   = b;
    in_tag      = tag;
    in_payload  = {a, b, ~b, {(DW-TW){1'b0}}, tag};
    cur_exp     = '{exp_res, (exp_res == '0), exp_br, tag, in_payload};
  endtask

  task automatic drive_add(input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input logic [TW-1:0] tag);
    drive(ADD, a, b, tag, a + b, 1'b0);
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while (sb_q.size() != 0 && k < budget) begin
      @(posedge clock);
      k++;
    end
    #1;
    check("drain_empty", sb_q.size(), 0);
  endtask

  // Scoreboard: push on input handshake, pop and compare on output handshake.
  always @(negedge clock) begin
    if (reset || flush) begin
      sb_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          $display("FAIL sb_unexpected: output tag %0h with nothing expected", out_tag);
        end else begin
          mon_e = sb_q.pop_front();
          check("sb_result", {out_result, out_zero, out_branch, out_tag},
                {mon_e.result, mon_e.zero, mon_e.branch, mon_e.tag});
          check("sb_payload", out_payload, mon_e.payload);
        end
      end
      if (in_valid && in_ready) sb_q.push_back(cur_exp);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int accepted;
    int sent;
    logic got;
    logic held_pending;
    logic [DW-1:0] held_res;
    logic [TW-1:0] held_tag;

    tbl[0]  = '{ADD,  32'd5,          32'd7,          32'd12,         1'b0};
    tbl[1]  = '{ADD,  32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0};
    tbl[2]  = '{SUB,  32'd3,          32'd5,          32'hFFFF_FFFE,  1'b0};
    tbl[3]  = '{SUB,  32'd9,          32'd9,          32'd0,          1'b0};
    tbl[4]  = '{SLL,  32'd1,          32'h24,         32'h10,         1'b0};
    tbl[5]  = '{SRL,  32'h8000_0000,  32'd31,         32'd1,          1'b0};
    tbl[6]  = '{SRA,  32'h8000_0000,  32'd4,          32'hF800_0000,  1'b0};
    tbl[7]  = '{SRA,  32'h4000_0000,  32'h21,         32'h2000_0000,  1'b0};
    tbl[8]  = '{SLT,  32'hFFFF_FFFF,  32'd1,          32'd1,          1'b0};
    tbl[9]  = '{SLTU, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0};
    tbl[10] = '{XOR,  32'hF0F0,       32'hFF00,       32'h0FF0,       1'b0};
    tbl[11] = '{OR,   32'hF0F0,       32'h0F0F,       32'hFFFF,       1'b0};
    tbl[12] = '{AND,  32'hF0F0,       32'hFF00,       32'hF000,       1'b0};
    tbl[13] = '{BEQ,  32'd7,          32'd7,          32'd1,          1'b1};
    tbl[14] = '{BNE,  32'd7,          32'd7,          32'd0,          1'b0};
    tbl[15] = '{BLT,  32'hFFFF_FFFF,  32'd1,          32'd1,          1'b1};
    tbl[16] = '{BGE,  32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0};
    tbl[17] = '{BLTU, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0};
    tbl[18] = '{BGEU, 32'hFFFF_FFFF,  32'd1,          32'd1,          1'b1};
    tbl[19] = '{6'h3F, 32'd5,         32'd5,          32'd0,          1'b0};

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    alu_control = '0; operand_a = '0; operand_b = '0; in_tag = '0; in_payload = '0;
    cur_exp = '0;

    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("in_ready_during_reset", in_ready, 1'b0);
    next_cycle();
    reset = 1'b0;
    @(negedge clock);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_occupancy", occupancy, 5'd0);
    check("rst_outputs", {out_result, out_zero, out_branch, out_tag}, '0);
    check("rst_payload", out_payload, '0);

    // Latency: accept at edge 0, visible after edge 3
    out_ready = 1'b1;
    next_cycle();
    drive(ADD, 32'd5, 32'd7, 6'h2A, 32'd12, 1'b0);
    next_cycle();
    in_valid = 1'b0;
    for (int k = 0; k < LAT - 1; k++) begin
      @(negedge clock);
      check("lat_early_valid", out_valid, 1'b0);
    end
    @(negedge clock);
    check("lat_valid", out_valid, 1'b1);
    check("lat_result", out_result, 32'd12);
    check("lat_zero", out_zero, 1'b0);
    check("lat_tag", out_tag, 6'h2A);
    next_cycle();
    drain(20);

    // Opcode table, one request per cycle
    next_cycle();
    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].op, tbl[i].a, tbl[i].b, 6'(i), tbl[i].res, tbl[i].br);
      @(negedge clock);
      check("tbl_in_ready", in_ready, 1'b1);
      next_cycle();
    end
    in_valid = 1'b0;
    drain(20);

    // Backpressure: fill to LATENCY, then stream out with no loss
    out_ready = 1'b0;
    accepted = 0;
    next_cycle();
    for (int c = 0; c < 8 && accepted < 6; c++) begin
      drive_add(DW'(accepted * 3 + 1), 32'd100, TW'(16 + accepted));
      @(negedge clock);
      if (in_ready) accepted++;
      next_cycle();
    end
    check("bp_accepts", accepted, 4);
    check("bp_occupancy", occupancy, 5'(LAT));
    check("bp_in_ready_full", in_ready, 1'b0);
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      check("bp_stream_valid", out_valid, 1'b1);
      got = in_valid && in_ready;
      next_cycle();
      if (got) accepted++;
      if (accepted < 6) drive_add(DW'(accepted * 3 + 1), 32'd100, TW'(16 + accepted));
      else in_valid = 1'b0;
    end
    check("bp_total_accepts", accepted, 6);
    drain(20);

    // Spaced requests with out_ready toggling; held output must not change
    sent = 0;
    held_pending = 1'b0;
    held_res = '0;
    held_tag = '0;
    for (int c = 0; c < 32; c++) begin
      out_ready = (c % 2) == 0;
      if (!in_valid && sent < 5 && (c % 2) == 0)
        drive_add(DW'(1000 + sent), DW'(sent), TW'(40 + sent));
      @(negedge clock);
      if (held_pending) begin
        check("hold_valid", out_valid, 1'b1);
        check("hold_data", {out_result, out_tag}, {held_res, held_tag});
      end
      held_pending = out_valid && !out_ready;
      held_res = out_result;
      held_tag = out_tag;
      got = in_valid && in_ready;
      next_cycle();
      if (got) begin
        in_valid = 1'b0;
        sent++;
      end
    end
    check("spaced_sent", sent, 5);
    out_ready = 1'b1;
    drain(20);

    // Flush with three in flight and a request offered in the flush cycle
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive_add(DW'(50 + k), 32'd1, TW'(60 + k));
      next_cycle();
    end
    in_valid = 1'b0;
    check("flush_pre_occupancy", occupancy, 5'd3);
    flush = 1'b1;
    drive_add(32'd77, 32'd1, 6'h3F);
    @(negedge clock);
    check("flush_in_ready", in_ready, 1'b0);
    next_cycle();
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_occupancy", occupancy, 5'd0);
    check("flush_out_valid", out_valid, 1'b0);
    out_ready = 1'b1;
    for (int k = 0; k < LAT + 2; k++) begin
      @(negedge clock);
      check("flush_no_output", out_valid, 1'b0);
    end
    next_cycle();

    // Reset with two in flight
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      drive_add(DW'(200 + k), 32'd3, TW'(20 + k));
      next_cycle();
    end
    in_valid = 1'b0;
    check("rst2_pre_occupancy", occupancy, 5'd2);
    reset = 1'b1;
    @(negedge clock);
    check("rst2_in_ready", in_ready, 1'b0);
    next_cycle();
    reset = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < LAT + 2; k++) begin
      @(negedge clock);
      check("rst2_out_valid", out_valid, 1'b0);
      check("rst2_outputs", {occupancy, out_result, out_zero, out_branch, out_tag}, '0);
      check("rst2_payload", out_payload, '0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
